pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register slice (main + skid); flush port and logic exist only with SKID_FLUSH_EN.
// Latency: 1 cycle from input transfer to out_valid when empty; strict FIFO order.
// Backpressure: in_ready is decoded from registered state only, so out_ready never reaches it combinationally.
module pipe_skid_reg #(
    parameter int                   BIT_WIDTH   = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef SKID_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] dataIn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] dataOut,
    output logic [1:0]           count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [BIT_WIDTH-1:0] mainReg;
    logic [BIT_WIDTH-1:0] mainNext;
    logic [BIT_WIDTH-1:0] skidReg;
    logic [BIT_WIDTH-1:0] skidNext;
    logic                 inXfer;
    logic                 outXfer;
    logic                 flushNow;

`ifdef SKID_FLUSH_EN
    assign flushNow = flush;
`else
    assign flushNow = 1'b0;
`endif

    assign inXfer  = in_valid && in_ready;
    assign outXfer = out_valid && out_ready;
    assign dataOut = mainReg;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        count     = 2'd0;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                count     = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        stateNext = state;
        mainNext  = mainReg;
        skidNext  = skidReg;
        case (state)
            EMPTY: begin
                if (inXfer) begin
                    stateNext = ONE;
                    mainNext  = dataIn;
                end
            end
            ONE: begin
                if (inXfer && outXfer) begin
                    mainNext = dataIn;
                end else if (inXfer) begin
                    stateNext = FULL;
                    skidNext  = dataIn;
                end else if (outXfer) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (outXfer) begin
                    stateNext = ONE;
                    mainNext  = skidReg;
                end
            end
            default: begin
                stateNext = EMPTY;
            end
        endcase
        // Flush discards everything, including any transfer in the same cycle.
        if (flushNow) begin
            stateNext = EMPTY;
            mainNext  = RESET_VALUE;
            skidNext  = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            mainReg <= RESET_VALUE;
            skidReg <= RESET_VALUE;
        end else begin
            state   <= stateNext;
            mainReg <= mainNext;
            skidReg <= skidNext;
        end
    end

endmodule
